apb_arb2: RTL and testbench

APB_ARB2 -- requirements
Module: apb_arb2

---
 rtl/apb_arb2.sv | 163 ++++++++++++++++
 tb/tb_apb_arb2.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/apb_arb2.sv
// Purpose: two-master APB arbiter sharing one slave port, round-robin on simultaneous requests.
// Latency: one IDLE arbitration cycle, one SETUP cycle, then ACCESS until slave pready or wait timeout.
// Backpressure: losing or late master sees pready=0 and waits; slave stalls are bounded by TIMEOUT.
module apb_arb2 #(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  // master 0
  input  logic        m0_psel,
  input  logic        m0_penable,
  input  logic        m0_pwrite,
  input  logic [31:0] m0_paddr,
  input  logic [31:0] m0_pwdata,
  input  logic [3:0]  m0_pstrb,
  input  logic [2:0]  m0_pprot,
  output logic        m0_pready,
  output logic [31:0] m0_prdata,
  output logic        m0_pslverr,
  // master 1
  input  logic        m1_psel,
  input  logic        m1_penable,
  input  logic        m1_pwrite,
  input  logic [31:0] m1_paddr,
  input  logic [31:0] m1_pwdata,
  input  logic [3:0]  m1_pstrb,
  input  logic [2:0]  m1_pprot,
  output logic        m1_pready,
  output logic [31:0] m1_prdata,
  output logic        m1_pslverr,
  // shared slave
  output logic        out_psel,
  output logic        out_penable,
  output logic        out_pwrite,
  output logic [31:0] out_paddr,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  output logic [2:0]  out_pprot,
  input  logic        out_pready,
  input  logic [31:0] out_prdata,
  input  logic        out_pslverr
);

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_g;
  logic        w_g_nxt;
  logic        r_last;
  logic        w_last_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;

  logic        w_fwd;
  logic        w_done;
  logic [31:0] w_rdata;
  logic        w_err;

  // penable from the masters carries no arbitration meaning; only psel opens a request
  logic        w_unused_penable;
  assign w_unused_penable = m0_penable ^ m1_penable;

  // state, grant, round-robin pointer and wait counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_g     <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_g     <= w_g_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // next-state logic, completion decode and slave-side drive enable
  always_comb begin
    w_state_nxt = r_state;
    w_g_nxt     = r_g;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_fwd       = 1'b0;
    w_done      = 1'b0;
    w_rdata     = 32'd0;
    w_err       = 1'b0;
    out_psel    = 1'b0;
    out_penable = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (m0_psel || m1_psel) begin
          // contention goes to the master that did not finish last
          w_g_nxt     = (m0_psel && m1_psel) ? ~r_last : m1_psel;
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        out_psel    = 1'b1;
        w_fwd       = 1'b1;
        w_cnt_nxt   = 8'd0;
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        out_psel    = 1'b1;
        out_penable = 1'b1;
        w_fwd       = 1'b1;
        if (out_pready) begin
          w_done      = 1'b1;
          w_rdata     = out_prdata;
          w_err       = out_pslverr;
          w_last_nxt  = r_g;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == LP_TIMEOUT) begin
          // slave hung: complete locally with an error and zero data
          w_done      = 1'b1;
          w_err       = 1'b1;
          w_last_nxt  = r_g;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // request fields come only from the granted master, zero when idle
  always_comb begin
    out_pwrite = 1'b0;
    out_paddr  = 32'd0;
    out_pwdata = 32'd0;
    out_pstrb  = 4'd0;
    out_pprot  = 3'd0;
    if (w_fwd) begin
      out_pwrite = r_g ? m1_pwrite : m0_pwrite;
      out_paddr  = r_g ? m1_paddr  : m0_paddr;
      out_pwdata = r_g ? m1_pwdata : m0_pwdata;
      out_pstrb  = r_g ? m1_pstrb  : m0_pstrb;
      out_pprot  = r_g ? m1_pprot  : m0_pprot;
    end
  end

  // completion is steered to the granted master only; the other sees all zeros
  always_comb begin
    m0_pready  = w_done & ~r_g;
    m0_pslverr = w_err  & ~r_g;
    m0_prdata  = r_g ? 32'd0 : w_rdata;
    m1_pready  = w_done & r_g;
    m1_pslverr = w_err  & r_g;
    m1_prdata  = r_g ? w_rdata : 32'd0;
  end

endmodule

// File: tb/tb_apb_arb2.sv
module tb_apb_arb2;

  logic        clock;
  logic        reset;
  logic        m0_psel, m0_penable, m0_pwrite;
  logic [31:0] m0_paddr, m0_pwdata;
  logic [3:0]  m0_pstrb;
  logic [2:0]  m0_pprot;
  logic        m0_pready, m0_pslverr;
  logic [31:0] m0_prdata;
  logic        m1_psel, m1_penable, m1_pwrite;
  logic [31:0] m1_paddr, m1_pwdata;
  logic [3:0]  m1_pstrb;
  logic [2:0]  m1_pprot;
  logic        m1_pready, m1_pslverr;
  logic [31:0] m1_prdata;
  logic        out_psel, out_penable, out_pwrite;
  logic [31:0] out_paddr, out_pwdata;
  logic [3:0]  out_pstrb;
  logic [2:0]  out_pprot;
  logic        out_pready, out_pslverr;
  logic [31:0] out_prdata;

  int n_chk = 0;
  int n_err = 0;

  apb_arb2 #(.TIMEOUT(15)) u_dut (
    .clock(clock), .reset(reset),
    .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
    .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata), .m0_pstrb(m0_pstrb), .m0_pprot(m0_pprot),
    .m0_pready(m0_pready), .m0_prdata(m0_prdata), .m0_pslverr(m0_pslverr),
    .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
    .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata), .m1_pstrb(m1_pstrb), .m1_pprot(m1_pprot),
    .m1_pready(m1_pready), .m1_prdata(m1_prdata), .m1_pslverr(m1_pslverr),
    .out_psel(out_psel), .out_penable(out_penable), .out_pwrite(out_pwrite),
    .out_paddr(out_paddr), .out_pwdata(out_pwdata), .out_pstrb(out_pstrb), .out_pprot(out_pprot),
    .out_pready(out_pready), .out_prdata(out_prdata), .out_pslverr(out_pslverr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Called on the negedge of an IDLE cycle with requests already driven and the
  // slave ready; walks SETUP and ACCESS and returns on the following IDLE negedge.
  task automatic do_xfer(input string tag, input logic g, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata);
    step();
    chk({tag, "_setup_psel"}, 32'(out_psel), 32'd1);
    chk({tag, "_setup_pen"}, 32'(out_penable), 32'd0);
    chk({tag, "_setup_addr"}, out_paddr, addr);
    chk({tag, "_setup_rdy"}, {30'd0, m1_pready, m0_pready}, 32'd0);
    step();
    chk({tag, "_acc_pen"}, 32'(out_penable), 32'd1);
    chk({tag, "_acc_wdata"}, out_pwdata, wdata);
    chk({tag, "_acc_rdy"}, {30'd0, m1_pready, m0_pready}, g ? 32'd2 : 32'd1);
    chk({tag, "_acc_rdata"}, g ? m1_prdata : m0_prdata, rdata);
    chk({tag, "_acc_other_rdata"}, g ? m0_prdata : m1_prdata, 32'd0);
    step();
    chk({tag, "_idle_psel"}, 32'(out_psel), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    m0_psel = 0; m0_penable = 0; m0_pwrite = 0; m0_paddr = 0; m0_pwdata = 0;
    m0_pstrb = 0; m0_pprot = 0;
    m1_psel = 0; m1_penable = 0; m1_pwrite = 0; m1_paddr = 0; m1_pwdata = 0;
    m1_pstrb = 0; m1_pprot = 0;
    out_pready = 1'b1; out_prdata = 32'd0; out_pslverr = 1'b0;

    // reset state
    #12;
    chk("rst_psel", 32'(out_psel), 32'd0);
    chk("rst_pen", 32'(out_penable), 32'd0);
    chk("rst_paddr", out_paddr, 32'd0);
    chk("rst_rdy", {30'd0, m1_pready, m0_pready}, 32'd0);
    step();
    reset = 1'b1;

    // m0 writes 0xA5 to 0x0; m1 fields differ and must be ignored
    step();
    m0_psel = 1; m0_pwrite = 1; m0_paddr = 32'h0; m0_pwdata = 32'h0000_00A5; m0_pstrb = 4'hF;
    m1_paddr = 32'h44; m1_pwdata = 32'hFFFF_FFFF;
    #1;
    chk("w_idle_psel", 32'(out_psel), 32'd0);
    do_xfer("w0", 1'b0, 32'h0, 32'h0000_00A5, 32'h0);
    m0_psel = 0;

    // round robin after a fresh reset
    reset = 1'b0;
    step();
    reset = 1'b1;
    m0_psel = 1; m0_paddr = 32'h10; m0_pwdata = 32'h0000_00A5;
    m1_psel = 1; m1_paddr = 32'h20; m1_pwdata = 32'h0000_005A;
    out_prdata = 32'h77;
    do_xfer("rr1", 1'b0, 32'h10, 32'hA5, 32'h77);
    do_xfer("rr2", 1'b1, 32'h20, 32'h5A, 32'h77);
    do_xfer("rr3", 1'b0, 32'h10, 32'hA5, 32'h77);
    m0_psel = 0;
    do_xfer("rr4", 1'b1, 32'h20, 32'h5A, 32'h77);
    m1_psel = 0;

    // m1 read with two slave wait cycles; m0 requests mid-transfer
    m1_psel = 1; m1_pwrite = 0; m1_paddr = 32'h4;
    out_pready = 0; out_prdata = 32'h0000_1234;
    step();
    chk("rd_setup_addr", out_paddr, 32'h4);
    chk("rd_setup_wr", 32'(out_pwrite), 32'd0);
    step();
    chk("rd_w1_rdy", {30'd0, m1_pready, m0_pready}, 32'd0);
    chk("rd_w1_rdata", m1_prdata, 32'd0);
    m0_psel = 1; m0_paddr = 32'h8; m0_pwrite = 1;
    step();
    chk("rd_w2_rdy", {30'd0, m1_pready, m0_pready}, 32'd0);
    chk("rd_w2_hold_addr", out_paddr, 32'h4);
    out_pready = 1;
    #1;
    chk("rd_done_rdy", {30'd0, m1_pready, m0_pready}, 32'd2);
    chk("rd_done_rdata", m1_prdata, 32'h0000_1234);
    chk("rd_done_m0_rdata", m0_prdata, 32'd0);
    step();
    chk("rd_idle_psel", 32'(out_psel), 32'd0);
    m1_psel = 0; out_pready = 0;

    // m0 now served with a slave that never answers
    step();
    chk("to_setup_addr", out_paddr, 32'h8);
    for (int i = 1; i <= 15; i++) begin
      step();
      chk($sformatf("to_wait%0d_rdy", i), 32'(m0_pready), 32'd0);
    end
    step();
    chk("to_rdy", 32'(m0_pready), 32'd1);
    chk("to_err", 32'(m0_pslverr), 32'd1);
    chk("to_rdata", m0_prdata, 32'd0);
    chk("to_pen", 32'(out_penable), 32'd1);
    m0_psel = 0;
    step();
    chk("to_idle_psel", 32'(out_psel), 32'd0);
    chk("to_idle_rdy", 32'(m0_pready), 32'd0);

    // reset during an m1 ACCESS phase
    m1_psel = 1; m1_paddr = 32'h30;
    step();
    step();
    chk("ra_acc_psel", 32'(out_psel), 32'd1);
    chk("ra_acc_pen", 32'(out_penable), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("ra_async_psel", 32'(out_psel), 32'd0);
    chk("ra_async_pen", 32'(out_penable), 32'd0);
    chk("ra_async_rdy", 32'(m1_pready), 32'd0);
    step();
    chk("ra_hold_rdy", 32'(m1_pready), 32'd0);
    reset = 1'b1;
    m0_psel = 1; m0_paddr = 32'h10; out_pready = 1;
    do_xfer("ra1", 1'b0, 32'h10, 32'hA5, 32'h0000_1234);
    m0_psel = 0;
    do_xfer("ra2", 1'b1, 32'h30, 32'h5A, 32'h0000_1234);
    m1_psel = 0;

    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
